player_action_ctrl: RTL and testbench
=====================================

PLAYER_ACTION_CTRL -- requirements
Module: player_action_ctrl

Interface
REQ-001 Parameter STARTUP_FRAMES, default 4: attack wind-up length, in frames.
REQ-002 Parameter ACTIVE_FRAMES, default 3: hitbox-live length, in frames.
REQ-003 Parameter RECOVER_FRAMES, default 8: attack recovery length, in frames.
REQ-004 Parameter HITSTUN_FRAMES, default 12: stun length after being hit, in frames.
REQ-005 Parameter BUFFER_FRAMES, default 6: lifetime of a buffered attack press, in frames.
REQ-006 clk  in  1  system clock.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 scen  in  1  one-cycle frame strobe; all state and counter updates occur only on cycles with scen=1.
REQ-009 btn_left, btn_right, btn_jump, btn_attack  in  1 each  debounced player buttons.
REQ-010 jump_active  in  1  airborne flag from the movement block.
REQ-011 hit_taken  in  1  one-frame pulse: opponent hitbox connected.
REQ-012 hp_zero  in  1  level: player health exhausted.
REQ-013 move_enable  out  1  movement block may update this frame.
REQ-014 move_left, move_right, jump  out  1 each  gated movement commands.
REQ-015 attack_active  out  1  hitbox live.
REQ-016 state  out  3  current state encoding (package constants).
REQ-017 busy  out  1  high in any attack, HITSTUN or KO state.

Function
REQ-018 States: IDLE=0, MOVE=1, ATK_STARTUP=2, ATK_ACTIVE=3, ATK_RECOVER=4, HITSTUN=5, KO=6; encoding 7 is unused and SHALL transition to IDLE on the next scen.
REQ-019 Attack press SHALL be a rising edge of btn_attack, sampled frame-to-frame at scen; holding the button SHALL NOT retrigger.
REQ-020 Transition priority on each scen, highest first: hp_zero -> KO; hit_taken -> HITSTUN; attack press (only from IDLE/MOVE with jump_active=0) -> ATK_STARTUP; exactly one of left/right pressed -> MOVE; otherwise IDLE.
REQ-021 Each timed state SHALL load frame_cnt=0 on entry, increment on scen, and exit when frame_cnt==N-1; a state with N=1 lasts one frame.
REQ-022 Timed-state exits: ATK_STARTUP -> ATK_ACTIVE; ATK_ACTIVE -> ATK_RECOVER; ATK_RECOVER -> IDLE; HITSTUN -> IDLE.
REQ-023 hit_taken during any attack state or HITSTUN SHALL restart HITSTUN with frame_cnt=0; attack_active SHALL drop on the same update.
REQ-024 KO SHALL be absorbing: only reset leaves it.
REQ-025 move_enable SHALL be 1 in IDLE and MOVE, and also whenever jump_active=1, so that an arc in progress always completes; it SHALL be 0 in all other cases.
REQ-026 Gating: move_left=btn_left, move_right=btn_right and jump=btn_jump in IDLE/MOVE; all three SHALL be 0 in other states.
REQ-027 attack_active SHALL be 1 exactly in ATK_ACTIVE, i.e. for ACTIVE_FRAMES frames, registered.
REQ-028 All outputs SHALL be registered and update one clk after the scen cycle that causes them.
REQ-029 frame_cnt width SHALL be the clog2 of the largest timing parameter, and it SHALL never wrap inside a state.

Reset
REQ-030 On reset: state=IDLE, frame_cnt=0, edge register=0, buffer cleared, and every output 0.
REQ-031 Reset asserted mid-attack or mid-stun SHALL abort immediately, with no residual attack_active.

Configuration
REQ-032 With ATTACK_BUFFER_EN defined:
- an attack press during jump_active or ATK_RECOVER SHALL be latched with a BUFFER_FRAMES countdown;
- the buffer SHALL fire ATK_STARTUP on the first eligible scen before expiry;
- hit_taken or hp_zero SHALL clear the buffer.
REQ-033 Without ATTACK_BUFFER_EN, those presses SHALL be discarded; no buffer logic is instantiated.

Structure
REQ-034 Package player_pkg SHALL hold the state encodings and the default frame-timing constants.
REQ-035 Sub-module frame_timer (loadable counter with terminal flag) SHALL be used for frame_cnt and for the buffer countdown.

Verification
REQ-036 Attack from IDLE, defaults -> attack_active high for exactly 3 scen frames, starting after 4 startup frames; IDLE reached after 15 frames total.
REQ-037 hit_taken in frame 2 of ATK_ACTIVE -> attack_active 0 next update; 12 HITSTUN frames; then IDLE.
REQ-038 hp_zero with simultaneous hit_taken and attack press -> KO; state stays 6 for 100 frames; reset -> IDLE and outputs 0.
REQ-039 btn_left+btn_right together in IDLE -> stays IDLE, move_enable=1, no MOVE.
REQ-040 Attack press while jump_active=1:
- with ATTACK_BUFFER_EN and landing 3 frames later -> ATK_STARTUP on landing frame;
- with ATTACK_BUFFER_EN and landing after 7 frames -> IDLE;
- without ATTACK_BUFFER_EN -> IDLE in both cases.
REQ-041 Reset asserted in ATK_ACTIVE between scen pulses -> state=0 and attack_active=0 immediately, without waiting for scen.

Source files
------------

// File: rtl/player_pkg.sv
// Shared definitions for the player action controller: state encodings,
// default frame timings and the frame-counter width helper.
package player_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_MOVE        = 3'd1,
    ST_ATK_STARTUP = 3'd2,
    ST_ATK_ACTIVE  = 3'd3,
    ST_ATK_RECOVER = 3'd4,
    ST_HITSTUN     = 3'd5,
    ST_KO          = 3'd6
  } state_e;

  localparam int unsigned DEF_STARTUP_FRAMES = 4;
  localparam int unsigned DEF_ACTIVE_FRAMES  = 3;
  localparam int unsigned DEF_RECOVER_FRAMES = 8;
  localparam int unsigned DEF_HITSTUN_FRAMES = 12;
  localparam int unsigned DEF_BUFFER_FRAMES  = 6;

  // Width able to hold N-1 for the largest of the given frame counts.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d,
                                            input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/player_action_ctrl_frame_timer.sv
// Loadable frame counter: clears on load, otherwise counts up on each
// enabled cycle and saturates at last_i, which raises done_o.
module frame_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] last_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q;

  assign done_o = (cnt_q == last_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (load_i)       cnt_q <= '0;
      else if (!done_o) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/player_action_ctrl.sv
// Player action FSM: movement gating, timed attack phases, hitstun and KO.
// Define ATTACK_BUFFER_EN to keep attack presses made while airborne or recovering.
module player_action_ctrl
  import player_pkg::*;
#(
  parameter int unsigned STARTUP_FRAMES = DEF_STARTUP_FRAMES,
  parameter int unsigned ACTIVE_FRAMES  = DEF_ACTIVE_FRAMES,
  parameter int unsigned RECOVER_FRAMES = DEF_RECOVER_FRAMES,
  parameter int unsigned HITSTUN_FRAMES = DEF_HITSTUN_FRAMES,
  parameter int unsigned BUFFER_FRAMES  = DEF_BUFFER_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scen,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       btn_attack,
  input  logic       jump_active,
  input  logic       hit_taken,
  input  logic       hp_zero,
  output logic       move_enable,
  output logic       move_left,
  output logic       move_right,
  output logic       jump,
  output logic       attack_active,
  output logic [2:0] state,
  output logic       busy
);

  localparam int unsigned CW = cnt_width(STARTUP_FRAMES, ACTIVE_FRAMES, RECOVER_FRAMES,
                                         HITSTUN_FRAMES, BUFFER_FRAMES);
  localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_FRAMES - 1);
  localparam logic [CW-1:0] ACTIVE_LAST  = CW'(ACTIVE_FRAMES - 1);
  localparam logic [CW-1:0] RECOVER_LAST = CW'(RECOVER_FRAMES - 1);
  localparam logic [CW-1:0] HITSTUN_LAST = CW'(HITSTUN_FRAMES - 1);

  state_e        state_q, state_d;
  logic          atk_prev_q;
  logic          move_enable_q, move_left_q, move_right_q, jump_q, attack_active_q, busy_q;
  logic          press, free, free_d, start_atk, buf_fire;
  logic          cnt_load, cnt_done;
  logic [CW-1:0] cnt_last;

  assign press     = btn_attack & ~atk_prev_q;
  assign free      = (state_q == ST_IDLE) || (state_q == ST_MOVE);
  assign free_d    = (state_d == ST_IDLE) || (state_d == ST_MOVE);
  assign start_atk = free && !jump_active && (press || buf_fire);

  always_comb begin
    cnt_last = '0;
    case (state_q)
      ST_ATK_STARTUP: cnt_last = STARTUP_LAST;
      ST_ATK_ACTIVE:  cnt_last = ACTIVE_LAST;
      ST_ATK_RECOVER: cnt_last = RECOVER_LAST;
      ST_HITSTUN:     cnt_last = HITSTUN_LAST;
      default:        cnt_last = '0;
    endcase
  end

  frame_timer #(.WIDTH(CW)) u_frame_timer (
    .clk    (clk),
    .reset  (reset),
    .en_i   (scen),
    .load_i (cnt_load),
    .last_i (cnt_last),
    .done_o (cnt_done)
  );

  // The counter restarts on every transition (including HITSTUN re-entry) and
  // only counts while a timed state is held.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b1;
    if (state_q == ST_KO) begin
      state_d = ST_KO;
    end else if (hp_zero) begin
      state_d = ST_KO;
    end else if (hit_taken) begin
      state_d = ST_HITSTUN;
    end else begin
      case (state_q)
        ST_IDLE, ST_MOVE: begin
          if (start_atk)                  state_d = ST_ATK_STARTUP;
          else if (btn_left ^ btn_right)  state_d = ST_MOVE;
          else                            state_d = ST_IDLE;
        end
        ST_ATK_STARTUP: begin
          if (cnt_done) state_d = ST_ATK_ACTIVE;
          else          cnt_load = 1'b0;
        end
        ST_ATK_ACTIVE: begin
          if (cnt_done) state_d = ST_ATK_RECOVER;
          else          cnt_load = 1'b0;
        end
        ST_ATK_RECOVER, ST_HITSTUN: begin
          if (cnt_done) state_d = ST_IDLE;
          else          cnt_load = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef ATTACK_BUFFER_EN
  localparam logic [CW-1:0] BUF_LAST = CW'(BUFFER_FRAMES - 1);

  logic buf_valid_q, buf_latch, buf_done;

  assign buf_latch = press && ((free && jump_active) || (state_q == ST_ATK_RECOVER));
  assign buf_fire  = buf_valid_q;

  frame_timer #(.WIDTH(CW)) u_buf_timer (
    .clk    (clk),
    .reset  (reset),
    .en_i   (scen & (buf_valid_q | buf_latch)),
    .load_i (buf_latch),
    .last_i (BUF_LAST),
    .done_o (buf_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
    end else if (scen) begin
      if (hp_zero || hit_taken)        buf_valid_q <= 1'b0;
      else if (buf_latch)              buf_valid_q <= 1'b1;
      else if (start_atk)              buf_valid_q <= 1'b0;
      else if (buf_valid_q && buf_done) buf_valid_q <= 1'b0;
    end
  end
`else
  assign buf_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      atk_prev_q      <= 1'b0;
      move_enable_q   <= 1'b0;
      move_left_q     <= 1'b0;
      move_right_q    <= 1'b0;
      jump_q          <= 1'b0;
      attack_active_q <= 1'b0;
      busy_q          <= 1'b0;
    end else if (scen) begin
      state_q         <= state_d;
      atk_prev_q      <= btn_attack;
      move_enable_q   <= free_d | jump_active;
      move_left_q     <= free_d & btn_left;
      move_right_q    <= free_d & btn_right;
      jump_q          <= free_d & btn_jump;
      attack_active_q <= (state_d == ST_ATK_ACTIVE);
      busy_q          <= ~free_d;
    end
  end

  assign state         = state_q;
  assign move_enable   = move_enable_q;
  assign move_left     = move_left_q;
  assign move_right    = move_right_q;
  assign jump          = jump_q;
  assign attack_active = attack_active_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_player_action_ctrl.sv
// Directed self-checking bench for player_action_ctrl (default timings);
// buffered-attack expectations follow ATTACK_BUFFER_EN.
module tb_player_action_ctrl;

`ifdef ATTACK_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scen = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0, btn_attack = 1'b0;
  logic       jump_active = 1'b0, hit_taken = 1'b0, hp_zero = 1'b0;
  logic       move_enable, move_left, move_right, jump, attack_active, busy;
  logic [2:0] state;
  logic [5:0] outs_v;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  player_action_ctrl #(
    .STARTUP_FRAMES (4),
    .ACTIVE_FRAMES  (3),
    .RECOVER_FRAMES (8),
    .HITSTUN_FRAMES (12),
    .BUFFER_FRAMES  (6)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .scen          (scen),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_jump      (btn_jump),
    .btn_attack    (btn_attack),
    .jump_active   (jump_active),
    .hit_taken     (hit_taken),
    .hp_zero       (hp_zero),
    .move_enable   (move_enable),
    .move_left     (move_left),
    .move_right    (move_right),
    .jump          (jump),
    .attack_active (attack_active),
    .state         (state),
    .busy          (busy)
  );

  // {move_enable, move_left, move_right, jump, attack_active, busy}
  assign outs_v = {move_enable, move_left, move_right, jump, attack_active, busy};

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame: a single-cycle scen, then a settle cycle; returns at a negedge.
  task automatic tick();
    @(negedge clk) scen = 1'b1;
    @(negedge clk) scen = 1'b0;
  endtask

  task automatic clear_inputs();
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0; btn_attack = 1'b0;
    jump_active = 1'b0; hit_taken = 1'b0; hp_zero = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  int unsigned exp_st, bad;
  int unsigned land[3];
  int unsigned land_exp[3];

  initial begin
    // Reset holds everything low even with scen and buttons active.
    scen = 1'b1; btn_left = 1'b1; btn_attack = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 0);
    check("rst_outs", 32'(outs_v), 0);
    scen = 1'b0;
    clear_inputs();
    @(negedge clk) reset = 1'b0;

    // Movement: both directions stay IDLE, one direction is MOVE.
    btn_left = 1'b1; btn_right = 1'b1;
    tick();
    check("lr_state", 32'(state), 0);
    check("lr_outs", 32'(outs_v), 32'(6'b111000));
    btn_left = 1'b0; btn_jump = 1'b1;
    tick();
    check("r_state", 32'(state), 1);
    check("r_outs", 32'(outs_v), 32'(6'b101100));
    clear_inputs();
    tick();
    check("idle_state", 32'(state), 0);
    check("idle_outs", 32'(outs_v), 32'(6'b100000));

    // No update without scen.
    btn_attack = 1'b1;
    repeat (3) @(negedge clk);
    check("noscen_state", 32'(state), 0);

    // Full attack from IDLE with the button held throughout.
    tick();
    check("press_state", 32'(state), 2);
    check("press_outs", 32'(outs_v), 32'(6'b000001));
    for (int i = 1; i <= 16; i++) begin
      btn_left    = (i == 1);
      jump_active = (i == 1);
      tick();
      exp_st = (i < 4) ? 2 : (i < 7) ? 3 : (i < 15) ? 4 : 0;
      check($sformatf("atk_state[%0d]", i), 32'(state), exp_st);
      check($sformatf("atk_active[%0d]", i), 32'(attack_active), 32'(i >= 4 && i < 7));
      if (i == 1) check("startup_gate", 32'(outs_v), 32'(6'b100001));
    end
    clear_inputs();

    // Hit during the second ACTIVE frame, then full HITSTUN.
    tick();
    btn_attack = 1'b1;
    tick();
    btn_attack = 1'b0;
    repeat (4) tick();
    check("hit_act1", 32'(state), 3);
    tick();
    check("hit_act2", 32'(attack_active), 1);
    hit_taken = 1'b1;
    tick();
    hit_taken = 1'b0;
    check("hit_state", 32'(state), 5);
    check("hit_atk_drop", 32'(attack_active), 0);
    for (int j = 1; j <= 12; j++) begin
      tick();
      check($sformatf("stun[%0d]", j), 32'(state), (j < 12) ? 5 : 0);
    end

    // Asynchronous reset in ACTIVE, between scen pulses.
    btn_attack = 1'b1;
    tick();
    btn_attack = 1'b0;
    repeat (4) tick();
    check("arst_pre", 32'(attack_active), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_state", 32'(state), 0);
    check("arst_outs", 32'(outs_v), 0);
    @(negedge clk) reset = 1'b0;

    // Attack pressed while airborne, landing after 3, 6 and 7 frames.
    land[0] = 3; land_exp[0] = BUF_EN ? 2 : 0;
    land[1] = 6; land_exp[1] = BUF_EN ? 2 : 0;
    land[2] = 7; land_exp[2] = 0;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      jump_active = 1'b1; btn_attack = 1'b1;
      tick();
      check($sformatf("air_state[%0d]", land[k]), 32'(state), 0);
      check($sformatf("air_men[%0d]", land[k]), 32'(move_enable), 1);
      btn_attack = 1'b0;
      repeat (land[k] - 1) tick();
      jump_active = 1'b0;
      tick();
      check($sformatf("land_state[%0d]", land[k]), 32'(state), land_exp[k]);
    end

    // KO wins over hit and attack, and is absorbing until reset.
    do_reset();
    btn_attack = 1'b1; hit_taken = 1'b1; hp_zero = 1'b1;
    tick();
    check("ko_state", 32'(state), 6);
    check("ko_outs", 32'(outs_v), 32'(6'b000001));
    hp_zero = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      btn_attack = k[0];
      hit_taken  = k[1];
      btn_left   = 1'b1;
      tick();
      if (state != 3'd6) bad++;
    end
    check("ko_hold_bad", bad, 0);
    reset = 1'b1;
    #1;
    check("ko_rst_state", 32'(state), 0);
    check("ko_rst_outs", 32'(outs_v), 0);
    clear_inputs();
    @(negedge clk) reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
